// File: rtl/pcie_egress_splitter_if.sv
// Request, AXI-stream TX and payload FIFO signals of the TLP egress splitter.
// The slave modport is the splitter's own view; master is the host/PCIe side.
// No state; pure signal bundle.
interface pcie_egress_splitter_if #(
  parameter int ADDR_W = 64
);
  logic              i_enable;
  logic              o_finished;
  logic              o_busy;
  logic [7:0]        i_command;
  logic [13:0]       i_flags;
  logic [ADDR_W-1:0] i_address;
  logic [9:0]        i_dword_cnt;
  logic [15:0]       i_requester_id;
  logic [7:0]        i_tag;
  logic [7:0]        o_tlp_count;
  logic              i_axi_egress_ready;
  logic [31:0]       o_axi_egress_data;
  logic [3:0]        o_axi_egress_keep;
  logic              o_axi_egress_last;
  logic              o_axi_egress_valid;
  logic              i_fifo_valid;
  logic [31:0]       i_fifo_data;
  logic              o_fifo_stb;

  modport slave (
    input  i_enable, i_command, i_flags, i_address, i_dword_cnt, i_requester_id, i_tag,
    input  i_axi_egress_ready, i_fifo_valid, i_fifo_data,
    output o_finished, o_busy, o_tlp_count,
    output o_axi_egress_data, o_axi_egress_keep, o_axi_egress_last, o_axi_egress_valid,
    output o_fifo_stb
  );

  modport master (
    output i_enable, i_command, i_flags, i_address, i_dword_cnt, i_requester_id, i_tag,
    output i_axi_egress_ready, i_fifo_valid, i_fifo_data,
    input  o_finished, o_busy, o_tlp_count,
    input  o_axi_egress_data, o_axi_egress_keep, o_axi_egress_last, o_axi_egress_valid,
    input  o_fifo_stb
  );
endinterface

// File: rtl/pcie_egress_splitter.sv
// Splits one MWr/MRd host request into MPS/MRRS-capped, 4KB-safe TLPs on a 32-bit AXI-stream.
// Latency: 1 PLAN cycle before each header, 1 NEXT cycle after each TLP; header/data beats stream.
// Backpressure: every beat holds on ready low; payload underrun drops valid, headers never bubble.
module pcie_egress_splitter #(
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int MAX_READ_DW    = 128,
  parameter int ADDR_W         = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pcie_egress_splitter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAN, S_HDR, S_DATA, S_NEXT, S_FINISHED
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [7:0]        r_cmd;
  logic [13:0]       r_flags;
  logic [15:0]       r_req_id;
  logic [ADDR_W-1:0] r_addr;
  logic [10:0]       r_rem;
  logic [10:0]       r_len;
  logic [7:0]        r_tag;
  logic              r_hdr4;
  logic [1:0]        r_beat;
  logic [10:0]       r_dcnt;
  logic [7:0]        r_tlp_count;

  logic [63:0]       w_addr64;
  logic              w_is_write;
  logic [10:0]       w_max;
  logic [10:0]       w_page_dw;
  logic [10:0]       w_len_plan;
  logic              w_hdr_last;
  logic              w_data_last;
  logic [31:0]       w_dw0;
  logic [31:0]       w_dw1;
  logic [31:0]       w_dw_hi;
  logic [31:0]       w_dw_lo;
  logic [31:0]       w_hdr_word;
  logic              w_valid;
  logic [31:0]       w_data;
  logic              w_last;
  logic              w_fifo_stb;

  // Address viewed as 64 bits so a 32-bit build simply sees zero upper bits.
  assign w_addr64    = 64'(r_addr);
  assign w_is_write  = r_cmd[6];
  assign w_max       = w_is_write ? 11'(MAX_PAYLOAD_DW) : 11'(MAX_READ_DW);
  assign w_page_dw   = 11'd1024 - {1'b0, w_addr64[11:2]};
  assign w_hdr_last  = (r_beat == (r_hdr4 ? 2'd3 : 2'd2));
  assign w_data_last = (r_dcnt == r_len - 11'd1);

  // fmt[0] (bit5) is owned by the splitter; len 1024 encodes as 0 through truncation.
  assign w_dw0   = {(r_cmd & 8'hDF) | {2'b00, r_hdr4, 5'b0_0000}, r_flags, r_len[9:0]};
  assign w_dw1   = {r_req_id, r_tag, (r_len == 11'd1) ? 8'h0F : 8'hFF};
  assign w_dw_hi = w_addr64[63:32];
  assign w_dw_lo = w_addr64[31:0] & 32'hFFFF_FFFC;

  // Length of the next TLP: remaining, capped by MPS/MRRS and by the 4KB page boundary.
  always_comb begin
    w_len_plan = r_rem;
    if (w_max < w_len_plan)     w_len_plan = w_max;
    if (w_page_dw < w_len_plan) w_len_plan = w_page_dw;
  end

  // Header beat selection; beat 2 carries the upper address only for 4DW headers.
  always_comb begin
    w_hdr_word = w_dw0;
    case (r_beat)
      2'd0:    w_hdr_word = w_dw0;
      2'd1:    w_hdr_word = w_dw1;
      2'd2:    w_hdr_word = r_hdr4 ? w_dw_hi : w_dw_lo;
      default: w_hdr_word = w_dw_lo;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and stream outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_data      = 32'h0;
    w_last      = 1'b0;
    w_fifo_stb  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_enable) w_state_nxt = S_PLAN;
      end
      S_PLAN: begin
        w_state_nxt = S_HDR;
      end
      S_HDR: begin
        w_valid = 1'b1;
        w_data  = w_hdr_word;
        w_last  = w_hdr_last && !w_is_write;
        if (bus.i_axi_egress_ready && w_hdr_last)
          w_state_nxt = w_is_write ? S_DATA : S_NEXT;
      end
      S_DATA: begin
        w_valid    = bus.i_fifo_valid;
        w_data     = bus.i_fifo_data;
        w_last     = w_data_last;
        w_fifo_stb = bus.i_fifo_valid && bus.i_axi_egress_ready;
        if (w_fifo_stb && w_data_last) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_state_nxt = (r_rem == r_len) ? S_FINISHED : S_PLAN;
      end
      S_FINISHED: begin
        if (!bus.i_enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, per-TLP planning, beat counters and per-TLP address/tag advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd       <= '0;
      r_flags     <= '0;
      r_req_id    <= '0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_len       <= '0;
      r_tag       <= '0;
      r_hdr4      <= 1'b0;
      r_beat      <= '0;
      r_dcnt      <= '0;
      r_tlp_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_enable) begin
            r_cmd       <= bus.i_command;
            r_flags     <= bus.i_flags;
            r_req_id    <= bus.i_requester_id;
            r_addr      <= bus.i_address & ~ADDR_W'(3);
            r_rem       <= (bus.i_dword_cnt == 10'd0) ? 11'd1024 : {1'b0, bus.i_dword_cnt};
            r_tag       <= bus.i_tag;
            r_tlp_count <= '0;
          end
        end
        S_PLAN: begin
          r_len  <= w_len_plan;
          r_hdr4 <= (w_addr64[63:32] != 32'h0);
          r_beat <= '0;
          r_dcnt <= '0;
        end
        S_HDR: begin
          if (bus.i_axi_egress_ready) r_beat <= r_beat + 2'd1;
        end
        S_DATA: begin
          if (w_fifo_stb) r_dcnt <= r_dcnt + 11'd1;
        end
        S_NEXT: begin
          r_rem       <= r_rem - r_len;
          r_addr      <= r_addr + ADDR_W'({r_len, 2'b00});
          r_tag       <= r_tag + 8'd1;
          r_tlp_count <= r_tlp_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_finished         = (r_state == S_FINISHED);
  assign bus.o_busy             = (r_state != S_IDLE);
  assign bus.o_tlp_count        = r_tlp_count;
  assign bus.o_axi_egress_data  = w_data;
  assign bus.o_axi_egress_keep  = 4'hF;
  assign bus.o_axi_egress_last  = w_last;
  assign bus.o_axi_egress_valid = w_valid;
  assign bus.o_fifo_stb         = w_fifo_stb;

endmodule

// File: tb/tb_pcie_egress_splitter.sv
// Scoreboard bench for pcie_egress_splitter: expected beats queued from a reference split model.
// Payload comes from a show-ahead FIFO model with optional gaps; ready optionally random.
// Monitor compares accepted beats on the falling edge and checks stall stability.
module tb_pcie_egress_splitter;
  localparam int MPS  = 32;
  localparam int MRRS = 512;
  localparam int AW   = 64;

  logic clk = 1'b0;
  logic rst;

  initial forever #5 clk = ~clk;

  pcie_egress_splitter_if #(.ADDR_W(AW)) bus ();

  pcie_egress_splitter #(
    .MAX_PAYLOAD_DW(MPS),
    .MAX_READ_DW   (MRRS),
    .ADDR_W        (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_pops    = 0;
  int          n_applied = 0;
  bit          mon_en    = 1'b0;
  bit          rdy_rand  = 1'b0;
  bit          gap_rand  = 1'b0;
  logic [32:0] exp_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] junk;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  // Input driver: ready and show-ahead FIFO, updated just after each rising edge.
  initial begin
    bus.i_axi_egress_ready = 1'b1;
    bus.i_fifo_valid       = 1'b0;
    bus.i_fifo_data        = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      while (n_applied < n_pops) begin
        if (fifo_q.size() > 0) junk = fifo_q.pop_front();
        n_applied++;
        bus.i_fifo_valid = 1'b0;
      end
      if (fifo_q.size() == 0)
        bus.i_fifo_valid = 1'b0;
      else if (!bus.i_fifo_valid)
        bus.i_fifo_valid = !gap_rand || ($urandom_range(0, 2) != 0);
      bus.i_fifo_data        = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      bus.i_axi_egress_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: scoreboard compare on accepted beats, stall stability, pop consistency.
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (mon_en) begin
      if (bus.o_fifo_stb) begin
        n_pops++;
        n_checks++;
        if (!(bus.o_axi_egress_valid && bus.i_axi_egress_ready)) begin
          n_errors++;
          $display("FAIL stb_without_beat: valid %b ready %b, required both 1",
                   bus.o_axi_egress_valid, bus.i_axi_egress_ready);
        end
      end
      if (prev_stall) begin
        n_checks++;
        if (bus.o_axi_egress_valid !== 1'b1 || bus.o_axi_egress_data !== prev_data ||
            bus.o_axi_egress_last !== prev_last) begin
          n_errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   bus.o_axi_egress_valid, bus.o_axi_egress_data, bus.o_axi_egress_last,
                   prev_data, prev_last);
        end
      end
      if (bus.o_axi_egress_valid && bus.i_axi_egress_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL beat_unexpected: got d=%h l=%b, required no beat",
                   bus.o_axi_egress_data, bus.o_axi_egress_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_axi_egress_last, bus.o_axi_egress_data} !== e) begin
            n_errors++;
            $display("FAIL beat: got d=%h l=%b, required d=%h l=%b",
                     bus.o_axi_egress_data, bus.o_axi_egress_last, e[31:0], e[32]);
          end
        end
      end
      prev_stall = bus.o_axi_egress_valid && !bus.i_axi_egress_ready;
      prev_data  = bus.o_axi_egress_data;
      prev_last  = bus.o_axi_egress_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference split: pushes expected beats and payload words; returns TLP and payload counts.
  task automatic plan_request(input logic [7:0] cmd, input logic [13:0] flags,
                              input logic [63:0] a, input logic [9:0] cnt,
                              input logic [15:0] rid, input logic [7:0] t0,
                              output int ntlp, output int ndw);
    int          rem;
    int          len;
    int          maxl;
    int          page;
    bit          wr;
    bit          h4;
    logic [63:0] addr;
    logic [7:0]  tag;
    logic [31:0] w;
    wr   = cmd[6];
    rem  = (cnt == 10'd0) ? 1024 : int'(cnt);
    addr = {a[63:2], 2'b00};
    tag  = t0;
    ntlp = 0;
    ndw  = 0;
    while (rem > 0) begin
      maxl = wr ? MPS : MRRS;
      page = (4096 - int'(addr[11:0])) / 4;
      len  = rem;
      if (maxl < len) len = maxl;
      if (page < len) len = page;
      h4 = (addr[63:32] != 32'h0);
      exp_q.push_back({1'b0, cmd[7], cmd[6], h4, cmd[4:0], flags, 10'(len)});
      exp_q.push_back({1'b0, rid, tag, (len == 1) ? 8'h0F : 8'hFF});
      if (h4) exp_q.push_back({1'b0, addr[63:32]});
      exp_q.push_back({!wr, addr[31:0]});
      if (wr) begin
        for (int k = 0; k < len; k++) begin
          w = $urandom;
          fifo_q.push_back(w);
          exp_q.push_back({(k == len - 1), w});
        end
        ndw += len;
      end
      rem  -= len;
      addr += 64'(len * 4);
      tag  += 8'd1;
      ntlp++;
    end
  endtask

  // Starts a request, scrambles request inputs after start, waits (bounded) for o_finished.
  task automatic run_request(input logic [7:0] cmd, input logic [63:0] a, input logic [9:0] cnt,
                             input logic [7:0] t0, output int ntlp, output int ndw,
                             output bit done);
    n_pops    = 0;
    n_applied = 0;
    plan_request(cmd, 14'h0A5, a, cnt, 16'hBEEF, t0, ntlp, ndw);
    @(posedge clk);
    #1;
    bus.i_command      = cmd;
    bus.i_flags        = 14'h0A5;
    bus.i_address      = a;
    bus.i_dword_cnt    = cnt;
    bus.i_requester_id = 16'hBEEF;
    bus.i_tag          = t0;
    bus.i_enable       = 1'b1;
    @(posedge clk);
    #1;
    bus.i_address   = {$urandom, $urandom};
    bus.i_dword_cnt = 10'($urandom);
    bus.i_tag       = 8'($urandom);
    bus.i_command   = 8'($urandom);
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (bus.o_finished) done = 1'b1;
    end
  endtask

  task automatic end_request();
    @(posedge clk);
    #1;
    bus.i_enable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_done(input string name, input bit done, input int ntlp, input int ndw);
    if (!done) begin
      n_errors++;
      $display("FAIL %s_timeout: o_finished never rose, required 1", name);
    end
    n_checks++;
    if (bus.o_tlp_count !== 8'(ntlp)) begin
      n_errors++;
      $display("FAIL %s_tlp_count: got %0d, required %0d", name, bus.o_tlp_count, ntlp);
    end
    n_checks++;
    if (n_pops !== ndw) begin
      n_errors++;
      $display("FAIL %s_pops: got %0d, required %0d", name, n_pops, ndw);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL %s_beats_left: got %0d outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_axi_egress_valid !== 1'b0 || bus.o_axi_egress_last !== 1'b0 ||
        bus.o_axi_egress_data !== 32'h0 || bus.o_fifo_stb !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_stream: got v=%b l=%b d=%h stb=%b, required all 0",
               bus.o_axi_egress_valid, bus.o_axi_egress_last, bus.o_axi_egress_data, bus.o_fifo_stb);
    end
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_finished !== 1'b0 || bus.o_tlp_count !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_status: got busy=%b fin=%b cnt=%0d, required 0/0/0",
               bus.o_busy, bus.o_finished, bus.o_tlp_count);
    end
    n_checks++;
    if (bus.o_axi_egress_keep !== 4'hF) begin
      n_errors++;
      $display("FAIL reset_keep: got %h, required f", bus.o_axi_egress_keep);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_write_split();
    int ntlp; int ndw; bit done;
    run_request(8'h40, 64'h1000, 10'd70, 8'h01, ntlp, ndw, done);
    check_done("write_split", done, ntlp, ndw);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_finished !== 1'b1 || bus.o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL finished_hold: got fin=%b busy=%b, required 1/1", bus.o_finished, bus.o_busy);
    end
    end_request();
    n_checks++;
    if (bus.o_finished !== 1'b0 || bus.o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL finished_release: got fin=%b busy=%b, required 0/0", bus.o_finished, bus.o_busy);
    end
  endtask

  task automatic test_read_page();
    int ntlp; int ndw; bit done;
    run_request(8'h00, 64'hFF8, 10'd4, 8'h10, ntlp, ndw, done);
    check_done("read_page", done, ntlp, ndw);
    end_request();
  endtask

  task automatic test_4dw_single();
    int ntlp; int ndw; bit done;
    run_request(8'h40, 64'h1_0000_0000, 10'd1, 8'h33, ntlp, ndw, done);
    check_done("hdr4_single", done, ntlp, ndw);
    end_request();
  endtask

  task automatic test_backpressure();
    int ntlp; int ndw; bit done;
    rdy_rand = 1'b1;
    gap_rand = 1'b1;
    run_request(8'h40, 64'h3FC0, 10'd70, 8'hFE, ntlp, ndw, done);
    check_done("backpressure", done, ntlp, ndw);
    rdy_rand = 1'b0;
    gap_rand = 1'b0;
    end_request();
  endtask

  task automatic test_read_1024();
    int ntlp; int ndw; bit done;
    run_request(8'h00, 64'h0, 10'd0, 8'h80, ntlp, ndw, done);
    check_done("read_1024", done, ntlp, ndw);
    end_request();
  endtask

  task automatic test_reset_mid();
    int ntlp; int ndw; bit got;
    n_pops    = 0;
    n_applied = 0;
    plan_request(8'h40, 14'h0A5, 64'h2000, 10'd70, 16'hBEEF, 8'h05, ntlp, ndw);
    @(posedge clk);
    #1;
    bus.i_command   = 8'h40;
    bus.i_address   = 64'h2000;
    bus.i_dword_cnt = 10'd70;
    bus.i_tag       = 8'h05;
    bus.i_enable    = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (bus.o_tlp_count == 8'd1) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL rst_mid_wait: tlp_count never reached 1, required 1");
    end
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    mon_en       = 1'b0;
    rst          = 1'b1;
    bus.i_enable = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_axi_egress_valid !== 1'b0 || bus.o_axi_egress_last !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.o_tlp_count !== 8'h0) begin
      n_errors++;
      $display("FAIL rst_mid: got v=%b l=%b busy=%b cnt=%0d, required 0/0/0/0",
               bus.o_axi_egress_valid, bus.o_axi_egress_last, bus.o_busy, bus.o_tlp_count);
    end
    rst = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (bus.o_axi_egress_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_quiet: got valid %b, required 0", bus.o_axi_egress_valid);
      end
    end
    n_pops    = 0;
    n_applied = 0;
    mon_en    = 1'b1;
  endtask

  task automatic test_back_to_back();
    int ntlp; int ndw; bit done;
    run_request(8'h40, 64'hFFFF_FFFC, 10'd3, 8'h20, ntlp, ndw, done);
    check_done("b2b_write", done, ntlp, ndw);
    end_request();
    run_request(8'h20, 64'h0000_00FF_FFFF_FFF0, 10'd5, 8'h21, ntlp, ndw, done);
    check_done("b2b_read", done, ntlp, ndw);
    end_request();
  endtask

  initial begin
    rst                = 1'b1;
    bus.i_enable       = 1'b0;
    bus.i_command      = 8'h0;
    bus.i_flags        = 14'h0;
    bus.i_address      = 64'h0;
    bus.i_dword_cnt    = 10'h0;
    bus.i_requester_id = 16'h0;
    bus.i_tag          = 8'h0;
    test_reset();
    test_write_split();
    test_read_page();
    test_4dw_single();
    test_backpressure();
    test_read_1024();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
